// File: rtl/ahb_lite_pkg.sv
// AHB-Lite shared definitions: transfer/burst/size/response codes and slave FSM states.
// Latency: n/a (types and helper function only).
// Backpressure: n/a.
// Shared between the SRAM slave and the master BFM. No ports.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Byte-lane enables for a transfer of 2^size bytes starting at lane 'off'.
  // Caller guarantees size <= 3 (at most 8 lanes).
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] off);
    logic [15:0] m;
    m = (16'd1 << (4'd1 << size)) - 16'd1;
    m = m << off;
    return m[7:0];
  endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between one master and one SRAM slave.
// Latency: n/a (wires only).
// Backpressure: HREADY/HREADYOUT carry the wait handshake.
// Ports: HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY (to slave);
//        HRDATA, HREADYOUT, HRESP (from slave).
interface ahb_lite_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  // HREADY comes from the interconnect (or a loopback), so both sides read it.
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HREADY, HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_array.sv
// Word-organised SRAM with per-byte write enables and a combinational read port.
// Latency: write lands at the clock edge, read is same-cycle.
// Backpressure: none; always accepts.
// Ports: clk, we (byte enables), addr (word index), wdata, rdata.
module ahb_lite_sram_array #(
  parameter int MEM_DEPTH  = 1024,
  parameter int DATA_WIDTH = 32,
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic [BYTES-1:0]      we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are deliberately not reset.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave fronting an on-chip SRAM; singles and INCR bursts, byte/half/word writes.
// Latency: data phase follows address phase after WAIT_STATES low cycles; error is 2 cycles.
// Backpressure: HREADYOUT low during wait states and ERR1; new address only sampled when HREADY.
// Ports: HCLK, HRESETn (sync, active-low), bus (ahb_lite_sram_slave_if.slave).
// Optional macro AHB_SRAM_ERR_EN: ERROR response for out-of-range, oversized or unaligned
// transfers; without it addresses wrap, sizes clamp and low address bits are aligned.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic                HCLK,
  input logic                HRESETn,
  ahb_lite_sram_slave_if.slave bus
);

  localparam int         BYTES    = DATA_WIDTH / 8;
  localparam int         IDX_W    = $clog2(MEM_DEPTH);
  localparam int         OFF_W    = $clog2(BYTES);
  localparam logic [2:0] MAX_SIZE = 3'(OFF_W);
  localparam logic [3:0] WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BYTES-1:0] mask_q, mask_d;
  logic             write_q, write_d;
  logic [2:0]       size_q, size_d;
  logic             hreadyout_q, hreadyout_d;
  logic             hresp_q, hresp_d;

  // Address-phase decode
  logic       accept;
  logic [2:0] addr_off;
  logic [2:0] size_cl;
  logic [2:0] align_mask;
  logic [2:0] off_al;
  logic [7:0] lm;
  logic       req_err;

  assign accept     = bus.HREADY & bus.HSEL & bus.HTRANS[1];
  assign addr_off   = bus.HADDR[2:0] & 3'(BYTES - 1);
  assign size_cl    = (bus.HSIZE > MAX_SIZE) ? MAX_SIZE : bus.HSIZE;
  assign align_mask = 3'((4'd1 << size_cl) - 4'd1);
  // Unaligned low bits are dropped so the lane mask always fits within the word.
  assign off_al     = addr_off & ~align_mask;
  assign lm         = lane_mask(size_cl, off_al);

`ifdef AHB_SRAM_ERR_EN
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(BYTES);
  logic [63:0] haddr_ext;
  assign haddr_ext = 64'(bus.HADDR);
  assign req_err   = (haddr_ext >= MEM_BYTES) | (bus.HSIZE > MAX_SIZE) |
                     ((addr_off & align_mask) != 3'd0);
`else
  assign req_err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all end with HREADYOUT high, so each is an
        // address-phase slot for the next transfer (no bubble between beats).
        state_d = ST_IDLE;
        if (accept) begin
          idx_d   = bus.HADDR[OFF_W +: IDX_W];
          mask_d  = lm[BYTES-1:0];
          size_d  = size_cl;
          write_d = bus.HWRITE & ~req_err;
          if (req_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
    // Outputs are registered from the next state so they are glitch-free.
    hreadyout_d = ~((state_d == ST_WAIT) || (state_d == ST_ERR1));
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      mask_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      write_q     <= write_d;
      size_q      <= size_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // Commit only in DATA; a reset on the closing edge abandons the write.
  logic [BYTES-1:0]      we;
  logic [DATA_WIDTH-1:0] rdata;

  assign we = (state_q == ST_DATA && write_q && HRESETn) ? mask_q : '0;

  ahb_lite_sram_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (HCLK),
    .we   (we),
    .addr (idx_q),
    .wdata(bus.HWDATA),
    .rdata(rdata)
  );

  assign bus.HRDATA    = (state_q == ST_DATA && !write_q) ? rdata : '0;
  assign bus.HREADYOUT = hreadyout_q;
`ifdef AHB_SRAM_ERR_EN
  assign bus.HRESP     = hresp_q;
`else
  assign bus.HRESP     = HRESP_OKAY;
`endif

  // Inputs accepted by the protocol but not needed for this memory.
  logic unused_bits;
  assign unused_bits = ^{bus.HBURST, bus.HTRANS[0], bus.HADDR, size_q, hresp_q};

endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

AHB-Lite subordinate (slave) fronting an on-chip word-organised SRAM: the responder end of the AHB-Lite bus that the team's master BFM drives. It handles single and INCR4/8/16 bursts with byte/halfword/word writes, a configurable number of wait states per data phase, and an optional two-cycle ERROR response. It sits behind the interconnect decoder (HSEL); in a single-slave bench its HREADYOUT is looped back to HREADY.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width; multiple of 8, max 64
- MEM_DEPTH, 1024, number of DATA_WIDTH words; power of two
- WAIT_STATES, 0, inserted HREADYOUT-low cycles per OKAY data phase, 0..15

- HCLK  in  1  bus clock; all logic on rising edge
- HRESETn  in  1  reset, synchronous, active-low
- HSEL  in  1  slave select from decoder
- HADDR  in  ADDR_WIDTH  byte address
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size (log2 bytes)
- HBURST  in  3  burst type; accepted, not used for address generation
- HWDATA  in  DATA_WIDTH  write data, valid in data phase
- HREADY  in  1  bus ready (end of previous transfer)
- HRDATA  out  DATA_WIDTH  read data, valid when HREADYOUT=1 in read data phase
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR

## Operation
- Address phase accepted on an edge where HREADY & HSEL & HTRANS[1]; captures word index, byte-lane mask, HWRITE, HSIZE into data-phase registers. IDLE/BUSY or HSEL=0: nothing captured, next state IDLE with OKAY, zero wait.
- Lane mask: (2^(2^HSIZE) − 1) << HADDR[log2(DATA_WIDTH/8)−1:0]; word index = HADDR >> log2(DATA_WIDTH/8), modulo MEM_DEPTH.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. Accepted transfer → WAIT if WAIT_STATES>0, else DATA; error transfer → ERR1.
  - WAIT: HREADYOUT=0; down-counter loaded with WAIT_STATES−1 on entry; → DATA when counter=0.
  - DATA: HREADYOUT=1, HRESP=0. Write: masked lanes of HWDATA committed to memory at the closing edge. Read: HRDATA = mem[word index] combinationally. Next: same rules as IDLE (pipelined back-to-back transfer, no bubble).
  - ERR1: HREADYOUT=0, HRESP=1. → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; new address phase sampled normally → as IDLE.
- HRDATA is 0 outside a read DATA cycle.
- Memory written only in DATA with HWRITE captured 1; never in WAIT, ERR1, ERR2.
- Write followed immediately by read of same word returns new data (commit edge precedes read data phase).
- Reset: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, counter=0, captured controls cleared. Memory contents not reset. Reset mid-WAIT or mid-ERR1 abandons the transfer; an in-flight write is not committed.

## Timing
- Zero-wait OKAY: address phase edge N, data phase cycle N+1, HREADYOUT=1 in that cycle, write committed edge N+2 / read data sampled edge N+2.
- Wait states: WAIT_STATES cycles of HREADYOUT=0 between address phase and DATA cycle.
- ERROR: exactly 2 data-phase cycles (ERR1, ERR2); WAIT_STATES not applied.
- Address-phase inputs ignored while HREADY=0.

## Configuration
- AHB_SRAM_ERR_EN defined: ERROR response for (a) HADDR ≥ MEM_DEPTH·DATA_WIDTH/8, (b) HSIZE > log2(DATA_WIDTH/8), (c) HADDR not aligned to HSIZE.
- Undefined: HRESP tied 0, ERR1/ERR2 unreachable; address wraps modulo memory size, oversized HSIZE treated as full width, unaligned low address bits forced to the HSIZE alignment.

## Structure
- ahb_lite_pkg: HTRANS codes, HBURST codes, HSIZE codes, HRESP_OKAY/HRESP_ERROR, shared with the master BFM.
- Sub-module ahb_lite_sram_array: MEM_DEPTH × DATA_WIDTH, per-byte write enables, combinational read port.

## Test plan
- WAIT_STATES=0: single write 0xDEADBEEF to 0x10, single read 0x10 → HRDATA=0xDEADBEEF, HREADYOUT never low, HRESP=0.
- Byte writes 0x11,0x22 to 0x21,0x23 over word 0x00000000 at 0x20; read 0x20 → 0x22001100.
- WAIT_STATES=2: INCR4 write 1,2,3,4 from 0x40 then INCR4 read → 1,2,3,4; each data phase shows exactly 2 HREADYOUT-low cycles.
- Back-to-back write 0xA5A5A5A5 to 0x80 then read 0x80 with no IDLE between → 0xA5A5A5A5.
- AHB_SRAM_ERR_EN, MEM_DEPTH=1024: write to 0x1000 → ERR1 (HRESP=1, HREADYOUT=0) then ERR2 (HRESP=1, HREADYOUT=1); memory at 0x0 unchanged. Without macro: same write lands at 0x0.
- WAIT_STATES=3: assert HRESETn=0 during WAIT of write 0x12345678 to 0x8 → next cycle HREADYOUT=1, HRESP=0; read 0x8 returns previous content.
